// File: rtl/wam_pkg.sv
// Shared constants and FSM encoding for the whack-a-mole scoring slice.
package wam_pkg;

    localparam int NUM_KEYS  = 9;
    localparam int CNT_W_DEF = 6;
    localparam int CNT_MAX   = (1 << CNT_W_DEF) - 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_CREDITED = 2'd2
    } state_e;

endpackage

// File: rtl/rise_fall_detect.sv
// One-bit history register producing single-cycle rise/fall strobes of din.
module rise_fall_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic hist_d;
    logic hist_q;

    always_comb begin
        hist_d = din;
        rise   = din & ~hist_q;
        fall   = ~din & hist_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/hit_scorer.sv
// Pairs lit lights with keypad presses: credits one hit per light, counts
// misses and wrong presses, and tracks lives for lives mode.
module hit_scorer #(
    parameter int NUM_KEYS = wam_pkg::NUM_KEYS,
    parameter int CNT_W    = wam_pkg::CNT_W_DEF,
    parameter int LIVES    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             lives_mode,
    input  logic             light_on,
    input  logic [3:0]       light_pos,
    input  logic             key_valid,
    input  logic [3:0]       key,
    output logic [CNT_W-1:0] score,
    output logic [CNT_W-1:0] misses,
    output logic [CNT_W-1:0] wrong_presses,
    output logic [1:0]       lives_left,
    output logic             hit_pulse,
    output logic             miss_pulse,
    output logic             out_of_lives
);

    import wam_pkg::*;

    localparam logic [3:0]       KEY_LIMIT  = 4'(NUM_KEYS);
    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;

    logic press;
    logic unlit;
    logic unused_key_release;
    logic unused_light_rise;

    rise_fall_detect u_key_edge (
        .clk   (clk),
        .reset (reset),
        .din   (key_valid),
        .rise  (press),
        .fall  (unused_key_release)
    );

    rise_fall_detect u_light_edge (
        .clk   (clk),
        .reset (reset),
        .din   (light_on),
        .rise  (unused_light_rise),
        .fall  (unlit)
    );

    state_e           state_d, state_q;
    logic [CNT_W-1:0] score_d, score_q;
    logic [CNT_W-1:0] misses_d, misses_q;
    logic [CNT_W-1:0] wrong_d, wrong_q;
    logic [1:0]       lives_d, lives_q;
    logic             hit_pulse_d, hit_pulse_q;
    logic             miss_pulse_d, miss_pulse_q;
    logic             ool_d, ool_q;

    logic active;
    logic match;
    logic hit;
    logic wrong;
    logic miss;
    logic penalty;

    always_comb begin
        active  = enable & ~ool_q;
        match   = (state_q == ST_ARMED) & light_on & (key < KEY_LIMIT) & (key == light_pos);
        hit     = active & press & match;
        wrong   = active & press & ~match;
        miss    = active & (state_q == ST_ARMED) & unlit;
        penalty = miss | wrong;
    end

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        misses_d     = misses_q;
        wrong_d      = wrong_q;
        lives_d      = lives_q;
        ool_d        = ool_q;
        hit_pulse_d  = hit;
        miss_pulse_d = penalty;

        if (!active) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:     if (light_on) state_d = ST_ARMED;
                ST_ARMED: begin
                    if (hit) begin
                        state_d = ST_CREDITED;
                    end else if (unlit) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CREDITED: if (unlit) state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end

        if (hit && score_q != CNT_SAT) begin
            score_d = score_q + CNT_W'(1);
        end
        if (miss && misses_q != CNT_SAT) begin
            misses_d = misses_q + CNT_W'(1);
        end
        if (wrong && wrong_q != CNT_SAT) begin
            wrong_d = wrong_q + CNT_W'(1);
        end

        // A simultaneous miss and wrong press costs a single life.
        if (penalty && lives_mode && lives_q != 2'd0) begin
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
                ool_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            score_q      <= '0;
            misses_q     <= '0;
            wrong_q      <= '0;
            lives_q      <= LIVES_INIT;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            ool_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            wrong_q      <= wrong_d;
            lives_q      <= lives_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            ool_q        <= ool_d;
        end
    end

    always_comb begin
        score         = score_q;
        misses        = misses_q;
        wrong_presses = wrong_q;
        lives_left    = lives_q;
        hit_pulse     = hit_pulse_q;
        miss_pulse    = miss_pulse_q;
        out_of_lives  = ool_q;
    end

endmodule

// File: tb/tb_hit_scorer.sv
// Directed scoreboard bench for hit_scorer: stimulus queues expected pulse
// snapshots, a negedge monitor pops and compares them.
module tb_hit_scorer;

    logic       clk = 1'b0;
    logic       reset, enable, lives_mode, light_on, key_valid;
    logic [3:0] light_pos, key;
    logic [5:0] score, misses, wrong_presses;
    logic [1:0] lives_left;
    logic       hit_pulse, miss_pulse, out_of_lives;

    always #5 clk = ~clk;

    hit_scorer #(
        .NUM_KEYS (9),
        .CNT_W    (6),
        .LIVES    (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .lives_mode    (lives_mode),
        .light_on      (light_on),
        .light_pos     (light_pos),
        .key_valid     (key_valid),
        .key           (key),
        .score         (score),
        .misses        (misses),
        .wrong_presses (wrong_presses),
        .lives_left    (lives_left),
        .hit_pulse     (hit_pulse),
        .miss_pulse    (miss_pulse),
        .out_of_lives  (out_of_lives)
    );

    typedef struct packed {
        logic       hit;
        logic       miss;
        logic [5:0] score;
        logic [5:0] misses;
        logic [5:0] wrong;
        logic [1:0] lives;
        logic       ool;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    function automatic ev_t mk(logic h, logic m, int s, int mi, int w, int l, logic o);
        ev_t e;
        e.hit    = h;
        e.miss   = m;
        e.score  = 6'(s);
        e.misses = 6'(mi);
        e.wrong  = 6'(w);
        e.lives  = 2'(l);
        e.ool    = o;
        return e;
    endfunction

    function automatic string ev_str(ev_t e);
        return $sformatf("hit=%0d miss=%0d score=%0d misses=%0d wrong=%0d lives=%0d ool=%0d",
                         e.hit, e.miss, e.score, e.misses, e.wrong, e.lives, e.ool);
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ev_t act, exp;
        if (hit_pulse || miss_pulse) begin
            act = '{hit_pulse, miss_pulse, score, misses, wrong_presses, lives_left, out_of_lives};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got %s expected no pulse", ev_str(act));
            end else begin
                exp = exp_q.pop_front();
                if (act != exp) begin
                    n_fail++;
                    $display("FAIL event: got %s expected %s", ev_str(act), ev_str(exp));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic light(logic on, logic [3:0] pos);
        light_pos = pos;
        light_on  = on;
        tick();
        tick();
    endtask

    task automatic press(logic [3:0] k);
        key       = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick();
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_score"}, score, 0);
        check({tag, "_misses"}, misses, 0);
        check({tag, "_wrong"}, wrong_presses, 0);
        check({tag, "_lives"}, lives_left, 3);
        check({tag, "_ool"}, out_of_lives, 0);
        check({tag, "_hit_pulse"}, hit_pulse, 0);
        check({tag, "_miss_pulse"}, miss_pulse, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1);
    end

    initial begin
        int s;
        reset = 1'b1; enable = 1'b0; lives_mode = 1'b0;
        light_on = 1'b0; light_pos = '0; key_valid = 1'b0; key = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check_reset_values("reset");

        // Single hit on pos 4, light off afterwards is not a miss
        enable = 1'b1;
        light(1'b1, 4'd4);
        exp_q.push_back(mk(1, 0, 1, 0, 0, 3, 0));
        press(4'd4);
        light(1'b0, 4'd4);
        check("hit_misses", misses, 0);
        check("hit_score", score, 1);

        // Second press on an already credited light is wrong
        light(1'b1, 4'd4);
        exp_q.push_back(mk(1, 0, 2, 0, 0, 3, 0));
        press(4'd4);
        exp_q.push_back(mk(0, 1, 2, 0, 1, 3, 0));
        press(4'd4);
        light(1'b0, 4'd4);
        check("double_score", score, 2);
        check("double_wrong", wrong_presses, 1);

        // Unhit light expires in lives mode
        lives_mode = 1'b1;
        light(1'b1, 4'd2);
        exp_q.push_back(mk(0, 1, 2, 1, 1, 2, 0));
        light(1'b0, 4'd2);
        check("miss_lives", lives_left, 2);
        check("miss_count", misses, 1);

        // Reset while armed, light dropped during reset
        light(1'b1, 4'd5);
        reset = 1'b1;
        tick();
        light_on = 1'b0;
        tick();
        reset = 1'b0;
        tick(); tick();
        check_reset_values("midreset");

        // Three wrong presses exhaust lives; later activity is frozen
        light(1'b1, 4'd1);
        exp_q.push_back(mk(0, 1, 0, 0, 1, 2, 0));
        press(4'd7);
        exp_q.push_back(mk(0, 1, 0, 0, 2, 1, 0));
        press(4'd7);
        exp_q.push_back(mk(0, 1, 0, 0, 3, 0, 1));
        press(4'd7);
        press(4'd7);
        press(4'd1);
        check("ool_wrong", wrong_presses, 3);
        check("ool_lives", lives_left, 0);
        check("ool_flag", out_of_lives, 1);
        check("ool_score", score, 0);
        light(1'b0, 4'd1);
        check("ool_misses", misses, 0);

        // Key held across reset release and enable rise: no press
        reset = 1'b1; enable = 1'b0; lives_mode = 1'b0;
        key = 4'd3; key_valid = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        enable = 1'b1;
        tick(); tick();
        key_valid = 1'b0;
        tick();
        check("held_key_wrong", wrong_presses, 0);
        check("held_key_ool", out_of_lives, 0);

        // 70 hits saturate the score at 63
        for (int i = 1; i <= 70; i++) begin
            s = (i > 63) ? 63 : i;
            light(1'b1, 4'(i % 9));
            exp_q.push_back(mk(1, 0, s, 0, 0, 3, 0));
            press(4'(i % 9));
            light(1'b0, 4'(i % 9));
        end
        check("sat_score", score, 63);

        // Out-of-range key never matches, even against an equal light_pos
        light(1'b1, 4'd9);
        exp_q.push_back(mk(0, 1, 63, 0, 1, 3, 0));
        press(4'd9);
        exp_q.push_back(mk(0, 1, 63, 1, 1, 3, 0));
        light(1'b0, 4'd9);

        // Miss and wrong press in the same cycle cost one life
        lives_mode = 1'b1;
        light(1'b1, 4'd3);
        exp_q.push_back(mk(0, 1, 63, 2, 2, 2, 0));
        light_on = 1'b0; key = 4'd3; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick(); tick();
        check("same_cycle_misses", misses, 2);
        check("same_cycle_wrong", wrong_presses, 2);
        check("same_cycle_lives", lives_left, 2);

        // Disabled: presses and expiries are ignored
        enable = 1'b0;
        light(1'b1, 4'd3);
        press(4'd3);
        press(4'd8);
        light(1'b0, 4'd3);
        check("disabled_wrong", wrong_presses, 2);
        check("disabled_misses", misses, 2);
        check("disabled_score", score, 63);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        check("pending_events", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hit_scorer.md
Name: hit_scorer

Overview:
Scoring stage between the light controller / keypad controller and the score displays. Pairs each lit-light instance with keypad presses, and credits at most one hit per light. Counts misses (light expired unhit) and wrong presses, and in lives mode decrements a life counter. Its registered score feeds the two-digit score display, and out_of_lives feeds the top-level game FSM as a game-over condition.

Parameters:
NUM_KEYS, 9, valid key/light indices are 0..NUM_KEYS-1
CNT_W, 6, width of score/misses/wrong_presses counters (saturate at 2^CNT_W-1)
LIVES, 3, initial lives loaded on reset; must be 1..3

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high; clears all state on the next clk edge
enable  in  1  high during PLAY (flick_lights); low freezes counters
lives_mode  in  1  1 = misses/wrong presses cost a life
light_on  in  1  a light is currently lit (lights != 0)
light_pos  in  4  index of lit light, valid while light_on
key_valid  in  1  keypad reports a key held (level)
key  in  4  index of key held, valid while key_valid
score  out  CNT_W  credited hits
misses  out  CNT_W  lights that expired unhit
wrong_presses  out  CNT_W  presses not matching a lit light
lives_left  out  2  remaining lives
hit_pulse  out  1  one-cycle pulse on credited hit
miss_pulse  out  1  one-cycle pulse on miss or wrong press
out_of_lives  out  1  sticky; lives_left reached 0 in lives mode

Behaviour:
- Reset (sync, active-high): score=misses=wrong_presses=0, lives_left=LIVES, pulses=0, out_of_lives=0, FSM=IDLE, edge-detect history regs=0.
- Edge detection: press = key_valid & ~key_valid_q; lit = light_on & ~light_on_q; unlit = ~light_on & light_on_q. History regs update every cycle, including when enable=0, so enabling mid-hold yields no false press.
- FSM states: IDLE, ARMED (light lit, not yet hit), CREDITED (hit taken, waiting for light off).
  - enable=0: go to / stay in IDLE. No counter or pulse changes.
  - IDLE: if light_on & enable -> ARMED. This covers a light already on when enable rises.
  - ARMED: press & key==light_pos & light_on -> CREDITED; score+1; hit_pulse.
  - ARMED: unlit -> IDLE; misses+1; miss_pulse.
  - CREDITED: unlit -> IDLE. Further matching presses count as wrong presses.
- Wrong press: press while enable and not (ARMED & key==light_pos & light_on); key>=NUM_KEYS is always wrong. Effect: wrong_presses+1; miss_pulse.
- Same-cycle miss (unlit in ARMED) and wrong press: both counters increment; one miss_pulse; lives decrement by 1 only.
- Lives: when lives_mode & miss_pulse condition & lives_left>0, lives_left-1. On the transition to 0, out_of_lives=1 and stays set until reset. With lives_mode=0, lives_left holds.
- Once out_of_lives=1: all counters freeze, the FSM sits in IDLE, and no pulses are produced.
- Counters saturate at 2^CNT_W-1 (63); no wrap.
- Latency: all outputs are registered and reflect an event one clk after the cycle in which the inputs show it.
- A reset asserted mid-light forces IDLE; a subsequent light-off produces no miss.

Decomposition:
- Shared package wam_pkg: NUM_KEYS, FSM state encoding (IDLE/ARMED/CREDITED), CNT_MAX constant.
- One natural sub-module: rise_fall_detect (1-bit history reg with sync reset; outputs rise and fall). Instantiated for key_valid and light_on.

Test Plan:
- Reset, enable=1, light_on=1 pos=4, press key 4 once -> score=1, one hit_pulse, misses=0; light off -> state IDLE, misses=0.
- Light pos=2 lit then off with no press -> misses=1, miss_pulse once; lives_mode=1 -> lives_left=2.
- Press key 4 twice on a single light pos=4 -> score=1, wrong_presses=1.
- lives_mode=1, LIVES=3, three wrong presses (key 7 vs pos 1) -> lives_left=0, out_of_lives=1; a 4th press leaves wrong_presses=3.
- 70 credited hits -> score saturates at 63. Also: key held while enable rises -> no press counted.
- Reset asserted while ARMED, then light goes off -> all outputs stay at reset values.
